// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS pipeline.
// Contents: ALU/MD/forwarding operation codes, the md_unit state encoding,
// PC and hazard-counter reset constants, and the hazard-counter decrement helper.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADDU = 4'd0,
        ALU_SUBU = 4'd1,
        ALU_OR   = 4'd2,
        ALU_AND  = 4'd3,
        ALU_SLL  = 4'd4,
        ALU_LUI  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_LINK = 4'd8,
        ALU_MFHI = 4'd9,
        ALU_MFLO = 4'd10
    } alu_op_e;

    // MD_MFHI/MD_MFLO mark HI/LO readers so they stall while the unit is busy.
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [2:0]  TUSE_NONE = 3'd7;

    // Hazard counters count down by one per stage and stick at zero.
    function automatic logic [2:0] sat_dec3(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle HI/LO multiply/divide unit.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   op_a_i, op_b_i  forwarded rs / rt operands
//   md_op_i         MD_* code of the instruction in EX
//   hi_o, lo_o      architectural HI / LO
//   busy_o          high while an operation is counting down
// A MULT/MULTU/DIV/DIVU or MTHI/MTLO is accepted only while idle. Results
// are written to HI/LO on the last busy cycle; division by zero leaves
// HI/LO untouched but still occupies the unit for DIV_CYCLES.
module md_unit
    import cpu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [3:0]  md_op_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o
);

    md_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    md_op_e      op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        signed_op;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] dvd, dvs, quo_u, rem_u, quo, rem;
    logic        neg_quo, neg_rem;

    assign signed_op = (op_q == MD_MULT) || (op_q == MD_DIV);

    // Sign-extending to 64 bits lets one unsigned multiplier produce the
    // exact signed product in its low 64 bits.
    assign ext_a = {{32{signed_op & a_q[31]}}, a_q};
    assign ext_b = {{32{signed_op & b_q[31]}}, b_q};
    assign prod  = ext_a * ext_b;

    // Signed division on magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend's sign. 0x8000_0000 / -1 wraps to
    // 0x8000_0000 without any special case.
    assign dvd     = (signed_op && a_q[31]) ? (32'd0 - a_q) : a_q;
    assign dvs     = (signed_op && b_q[31]) ? (32'd0 - b_q) : b_q;
    assign quo_u   = dvd / dvs;
    assign rem_u   = dvd % dvs;
    assign neg_quo = signed_op & (a_q[31] ^ b_q[31]);
    assign neg_rem = signed_op & a_q[31];
    assign quo     = neg_quo ? (32'd0 - quo_u) : quo_u;
    assign rem     = neg_rem ? (32'd0 - rem_u) : rem_u;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                case (md_op_e'(md_op_i))
                    MD_MULT, MD_MULTU: begin
                        state_d = MD_BUSY;
                        cnt_d   = 16'(MULT_CYCLES - 1);
                        op_d    = md_op_e'(md_op_i);
                        a_d     = op_a_i;
                        b_d     = op_b_i;
                    end
                    MD_DIV, MD_DIVU: begin
                        state_d = MD_BUSY;
                        cnt_d   = 16'(DIV_CYCLES - 1);
                        op_d    = md_op_e'(md_op_i);
                        a_d     = op_a_i;
                        b_d     = op_b_i;
                    end
                    MD_MTHI: hi_d = op_a_i;
                    MD_MTLO: lo_d = op_a_i;
                    default: ;
                endcase
            end
            MD_BUSY: begin
                if (cnt_q == 16'd0) begin
                    state_d = MD_IDLE;
                    if (op_q == MD_MULT || op_q == MD_MULTU) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand latches only matter while busy, so they need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the five-stage MIPS pipeline.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   rs_val, rt_val, imm32, shamt operands from ID/EX
//   alu_op, md_op, src_b_imm     operation select
//   fwd_a_sel, fwd_b_sel         operand forwarding select
//   bypass_mem, bypass_wb        forwarded values
//   raddr0, raddr1, waddr, wen   hazard/write addresses, write enable
//   pc, tuse0, tuse1, tnew       PC and hazard counters
//   ex_stall                     combinational stall request to the hazard unit
//   md_busy                      multiply/divide unit counting
//   *_q                          registered EX/Mem payload
// While ex_stall is high the EX/Mem register takes a bubble and pc_q holds.
module ex_stage
    import cpu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] imm32,
    input  logic [4:0]  shamt,
    input  logic [3:0]  alu_op,
    input  logic [3:0]  md_op,
    input  logic        src_b_imm,
    input  logic [1:0]  fwd_a_sel,
    input  logic [1:0]  fwd_b_sel,
    input  logic [31:0] bypass_mem,
    input  logic [31:0] bypass_wb,
    input  logic [4:0]  raddr0,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  waddr,
    input  logic        wen,
    input  logic [31:0] pc,
    input  logic [2:0]  tuse0,
    input  logic [2:0]  tuse1,
    input  logic [2:0]  tnew,
    output logic        ex_stall,
    output logic        md_busy,
    output logic [31:0] alu_out_q,
    output logic [31:0] dm_wdata_q,
    output logic [31:0] pc_q,
    output logic [4:0]  waddr_q,
    output logic [4:0]  raddr0_q,
    output logic [4:0]  raddr1_q,
    output logic        wen_q,
    output logic [2:0]  tuse0_q,
    output logic [2:0]  tuse1_q,
    output logic [2:0]  tnew_q
);

    logic        [31:0] op_a, fwd_b, op_b;
    logic signed [31:0] op_a_s, op_b_s;
    logic        [31:0] hi, lo, alu_res;

    logic [31:0] alu_out_d, dm_wdata_d, pc_d;
    logic [4:0]  waddr_d, raddr0_d, raddr1_d;
    logic        wen_d;
    logic [2:0]  tuse0_d, tuse1_d, tnew_d;

    always_comb begin
        case (fwd_sel_e'(fwd_a_sel))
            FWD_MEM: op_a = bypass_mem;
            FWD_WB:  op_a = bypass_wb;
            default: op_a = rs_val;
        endcase
        case (fwd_sel_e'(fwd_b_sel))
            FWD_MEM: fwd_b = bypass_mem;
            FWD_WB:  fwd_b = bypass_wb;
            default: fwd_b = rt_val;
        endcase
    end

    assign op_b   = src_b_imm ? imm32 : fwd_b;
    assign op_a_s = op_a;
    assign op_b_s = op_b;

    md_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md (
        .clk    (clk),
        .reset  (reset),
        .op_a_i (op_a),
        .op_b_i (fwd_b),
        .md_op_i(md_op),
        .hi_o   (hi),
        .lo_o   (lo),
        .busy_o (md_busy)
    );

    // The issuing cycle sees md_busy low, so a start never stalls itself.
    assign ex_stall = (md_op_e'(md_op) != MD_NONE) && md_busy;

    always_comb begin
        case (alu_op_e'(alu_op))
            ALU_ADDU: alu_res = op_a + op_b;
            ALU_SUBU: alu_res = op_a - op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_SLL:  alu_res = op_b << shamt;
            ALU_LUI:  alu_res = imm32 << 16;
            ALU_SLT:  alu_res = {31'd0, op_a_s < op_b_s};
            ALU_SLTU: alu_res = {31'd0, op_a < op_b};
            ALU_LINK: alu_res = pc + 32'd8;
            ALU_MFHI: alu_res = hi;
            ALU_MFLO: alu_res = lo;
            default:  alu_res = 32'd0;
        endcase
    end

    always_comb begin
        alu_out_d  = alu_res;
        dm_wdata_d = fwd_b;
        pc_d       = pc;
        waddr_d    = waddr;
        raddr0_d   = raddr0;
        raddr1_d   = raddr1;
        wen_d      = wen;
        tuse0_d    = sat_dec3(tuse0);
        tuse1_d    = sat_dec3(tuse1);
        tnew_d     = sat_dec3(tnew);
        if (ex_stall) begin
            // Bubble: no write, no read dependence; data and PC hold.
            alu_out_d  = alu_out_q;
            dm_wdata_d = dm_wdata_q;
            pc_d       = pc_q;
            waddr_d    = 5'd0;
            raddr0_d   = 5'd0;
            raddr1_d   = 5'd0;
            wen_d      = 1'b0;
            tuse0_d    = TUSE_NONE;
            tuse1_d    = TUSE_NONE;
            tnew_d     = 3'd0;
        end
    end

    // EX/Mem register
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out_q  <= '0;
            dm_wdata_q <= '0;
            pc_q       <= PC_RESET;
            waddr_q    <= '0;
            raddr0_q   <= '0;
            raddr1_q   <= '0;
            wen_q      <= 1'b0;
            tuse0_q    <= TUSE_NONE;
            tuse1_q    <= TUSE_NONE;
            tnew_q     <= '0;
        end else begin
            alu_out_q  <= alu_out_d;
            dm_wdata_q <= dm_wdata_d;
            pc_q       <= pc_d;
            waddr_q    <= waddr_d;
            raddr0_q   <= raddr0_d;
            raddr1_q   <= raddr1_d;
            wen_q      <= wen_d;
            tuse0_q    <= tuse0_d;
            tuse1_q    <= tuse1_d;
            tnew_q     <= tnew_d;
        end
    end

endmodule
